// File: rtl/clock_counter.sv
// clock_counter: 12-hour BCD wall clock (hh:mm:ss + AM/PM) advancing one second per enabled cycle
module clock_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    output logic       pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss
);
    logic       r_pm;
    logic [7:0] r_hh, r_mm, r_ss;
    logic [7:0] w_ss_nx, w_mm_nx, w_hh_nx;
    logic       w_min_carry, w_hr_carry;

    function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
        return v == 8'h59 ? 8'h00 :
               v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        w_min_carry = ena && r_ss == 8'h59;
        w_hr_carry  = w_min_carry && r_mm == 8'h59;
        w_ss_nx     = bcd_inc59(r_ss);
        w_mm_nx     = bcd_inc59(r_mm);
        w_hh_nx     = r_hh == 8'h12 ? 8'h01 :
                      r_hh == 8'h09 ? 8'h10 : {r_hh[7:4], r_hh[3:0] + 4'd1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pm <= 1'b0;
            r_hh <= 8'h12;
            r_mm <= 8'h00;
            r_ss <= 8'h00;
        end else if (ena) begin
            r_ss <= w_ss_nx;
            if (w_min_carry) r_mm <= w_mm_nx;
            if (w_hr_carry) r_hh <= w_hh_nx;
            // the 11 -> 12 hour step is the only point where AM/PM flips
            if (w_hr_carry && r_hh == 8'h11) r_pm <= ~r_pm;
        end
    end

    assign pm = r_pm;
    assign hh = r_hh;
    assign mm = r_mm;
    assign ss = r_ss;
endmodule

// File: tb/tb_clock_counter.sv
// tb_clock_counter: checks clock_counter against an elapsed-seconds model plus literal time points
module tb_clock_counter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0;
    logic       pm;
    logic [7:0] hh, mm, ss;
    int         n_checks = 0;
    int         n_fail = 0;
    int         t_model = 0;

    clock_counter dut (
        .clk  (clk),
        .reset(reset),
        .ena  (ena),
        .pm   (pm),
        .hh   (hh),
        .mm   (mm),
        .ss   (ss)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic logic [24:0] expect_of(input int t);
        int h24 = t / 3600;
        int h12 = h24 % 12;
        if (h12 == 0) h12 = 12;
        return {h24 >= 12, bcd(h12), bcd((t / 60) % 60), bcd(t % 60)};
    endfunction

    // model: seconds elapsed since midnight
    always @(posedge clk or posedge reset) begin
        if (reset) t_model <= 0;
        else if (ena) t_model <= (t_model + 1) % 86400;
    end

    always @(negedge clk) begin
        n_checks++;
        if ({pm, hh, mm, ss} !== expect_of(t_model)) begin
            n_fail++;
            $display("FAIL model t=%0d: got pm=%b %h:%h:%h, expected %h", t_model, pm, hh, mm, ss,
                     expect_of(t_model));
        end
    end

    task automatic chk(input string name, input logic ep, input logic [7:0] eh, em, es);
        n_checks++;
        if ({pm, hh, mm, ss} !== {ep, eh, em, es}) begin
            n_fail++;
            $display("FAIL %s: got pm=%b %h:%h:%h, expected pm=%b %h:%h:%h", name, pm, hh, mm, ss,
                     ep, eh, em, es);
        end
    endtask

    task automatic tick(input logic e);
        ena = e;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks_sparse(input int n);
        for (int i = 0; i < n; i++) begin
            tick(1'b1);
            tick(1'b0);
        end
    endtask

    initial begin
        repeat (2) tick(1'b0);
        reset = 1'b0;
        chk("reset_vals", 1'b0, 8'h12, 8'h00, 8'h00);
        repeat (10) tick(1'b0);
        chk("hold_ena0", 1'b0, 8'h12, 8'h00, 8'h00);
        ticks_sparse(9);
        chk("ss09", 1'b0, 8'h12, 8'h00, 8'h09);
        ticks_sparse(1);
        chk("ss10", 1'b0, 8'h12, 8'h00, 8'h10);
        ticks_sparse(50);
        chk("mm01", 1'b0, 8'h12, 8'h01, 8'h00);
        ticks_sparse(65);
        chk("t_12_02_05", 1'b0, 8'h12, 8'h02, 8'h05);
        ena = 1'b1;
        #2 reset = 1'b1;
        #1 chk("async_reset", 1'b0, 8'h12, 8'h00, 8'h00);
        repeat (3) tick(1'b1);
        chk("reset_priority", 1'b0, 8'h12, 8'h00, 8'h00);
        reset = 1'b0;
        tick(1'b1);
        chk("resume_01", 1'b0, 8'h12, 8'h00, 8'h01);
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 86400; i++) begin
            tick(1'b1);
            case (i)
                3599:  chk("t_12_59_59am", 1'b0, 8'h12, 8'h59, 8'h59);
                3600:  chk("t_01am", 1'b0, 8'h01, 8'h00, 8'h00);
                35999: chk("t_09_59_59am", 1'b0, 8'h09, 8'h59, 8'h59);
                36000: chk("t_10am", 1'b0, 8'h10, 8'h00, 8'h00);
                43199: chk("t_11_59_59am", 1'b0, 8'h11, 8'h59, 8'h59);
                43200: chk("t_12pm", 1'b1, 8'h12, 8'h00, 8'h00);
                46799: chk("t_12_59_59pm", 1'b1, 8'h12, 8'h59, 8'h59);
                46800: chk("t_01pm", 1'b1, 8'h01, 8'h00, 8'h00);
                55665: chk("t_03_27_45pm", 1'b1, 8'h03, 8'h27, 8'h45);
                86399: chk("t_11_59_59pm", 1'b1, 8'h11, 8'h59, 8'h59);
                86400: chk("t_full_day", 1'b0, 8'h12, 8'h00, 8'h00);
                default: ;
            endcase
        end
        repeat (3) tick(1'b0);
        chk("hold_after_day", 1'b0, 8'h12, 8'h00, 8'h00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
